fetch_queue: RTL and testbench

- Parametrised instruction prefetch buffer between the ibus and the decode stage.
- Owns the fetch PC. Issues sequential ibus requests while queue space remains.
- Buffers {pc, instr} pairs in a DEPTH-entry FIFO. Decode drains it with a valid/ready handshake.
- A redirect from execute (jump or branch) flushes the queue and restarts fetch from the new PC. A response already in flight at the redirect is discarded without violating the bus hold rule.

---
 rtl/fetch_queue.sv | 137 +++++++++++++
 tb/tb_fetch_queue.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Instruction prefetch buffer: owns the fetch PC, issues sequential ibus requests
// and queues {pc, instr} pairs for decode; redirects flush and restart fetch.
module fetch_queue #(
  parameter int                 ADDR_W   = 64,
  parameter int                 INST_W   = 32,
  parameter int                 DEPTH    = 4,
  parameter logic [ADDR_W-1:0]  RESET_PC = ADDR_W'(64'h8000_0000)
) (
  input  logic                    clk,
  input  logic                    reset,
  output logic                    ireq_valid,
  output logic [ADDR_W-1:0]       ireq_addr,
  input  logic                    iresp_data_ok,
  input  logic [INST_W-1:0]       iresp_data,
  input  logic                    redirect_valid,
  input  logic [ADDR_W-1:0]       redirect_pc,
  output logic                    out_valid,
  output logic [ADDR_W-1:0]       out_pc,
  output logic [INST_W-1:0]       out_instr,
  input  logic                    out_ready,
  output logic [$clog2(DEPTH):0]  out_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {
    S_FETCH   = 1'b0,
    S_DISCARD = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0]  pending_pc_q, pending_pc_d;
  logic               req_q, req_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [PTR_W-1:0]   head_q, head_d;
  logic [PTR_W-1:0]   tail_q, tail_d;

  logic [ADDR_W-1:0]  pc_mem    [DEPTH];
  logic [INST_W-1:0]  instr_mem [DEPTH];

  logic push;
  logic pop;

  // A response only counts as a push when it answers a live FETCH request.
  assign push = (state_q == S_FETCH) && req_q && iresp_data_ok && !redirect_valid;
  assign pop  = out_valid && out_ready && !redirect_valid;

  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    pending_pc_d = pending_pc_q;
    req_d        = req_q;
    count_d      = count_q;
    head_d       = head_q;
    tail_d       = tail_q;

    if (redirect_valid) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      req_d   = 1'b1;
      if (state_q == S_DISCARD) begin
        if (iresp_data_ok) begin
          fetch_pc_d = redirect_pc;
          state_d    = S_FETCH;
        end else begin
          pending_pc_d = redirect_pc;
        end
      end else if (req_q && !iresp_data_ok) begin
        // The outstanding request cannot be withdrawn; wait it out in DISCARD.
        state_d      = S_DISCARD;
        pending_pc_d = redirect_pc;
      end else begin
        fetch_pc_d = redirect_pc;
      end
    end else begin
      if (push) begin
        tail_d     = tail_q + PTR_W'(1);
        fetch_pc_d = fetch_pc_q + ADDR_W'(4);
      end
      if (pop) begin
        head_d = head_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);

      if (state_q == S_DISCARD) begin
        req_d = 1'b1;
        if (iresp_data_ok) begin
          fetch_pc_d = pending_pc_q;
          state_d    = S_FETCH;
        end
      end else if (req_q && !iresp_data_ok) begin
        req_d = 1'b1;
      end else begin
        req_d = (count_d < CNT_W'(DEPTH));
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_FETCH;
      fetch_pc_q   <= RESET_PC;
      pending_pc_q <= '0;
      req_q        <= 1'b0;
      count_q      <= '0;
      head_q       <= '0;
      tail_q       <= '0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      pending_pc_q <= pending_pc_d;
      req_q        <= req_d;
      count_q      <= count_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
    end
  end

  // Queue storage carries no reset; occupancy gating keeps stale entries invisible.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[tail_q]    <= fetch_pc_q;
      instr_mem[tail_q] <= iresp_data;
    end
  end

  assign ireq_valid = req_q;
  assign ireq_addr  = fetch_pc_q;
  assign out_valid  = (count_q != '0);
  assign out_count  = count_q;
  assign out_pc     = out_valid ? pc_mem[head_q]    : '0;
  assign out_instr  = out_valid ? instr_mem[head_q] : '0;

endmodule

// File: tb/tb_fetch_queue.sv
// Randomised bench for fetch_queue against a queue-level reference model,
// plus directed scenarios with hand-derived expectations.
module tb_fetch_queue;

  localparam int ADDR_W = 64;
  localparam int INST_W = 32;
  localparam int DEPTH  = 4;
  localparam logic [63:0] RESET_PC = 64'h8000_0000;

  logic                   clk = 1'b0;
  logic                   reset = 1'b0;
  logic                   ireq_valid;
  logic [ADDR_W-1:0]      ireq_addr;
  logic                   iresp_data_ok = 1'b0;
  logic [INST_W-1:0]      iresp_data = '0;
  logic                   redirect_valid = 1'b0;
  logic [ADDR_W-1:0]      redirect_pc = '0;
  logic                   out_valid;
  logic [ADDR_W-1:0]      out_pc;
  logic [INST_W-1:0]      out_instr;
  logic                   out_ready = 1'b0;
  logic [$clog2(DEPTH):0] out_count;

  fetch_queue #(
    .ADDR_W(ADDR_W), .INST_W(INST_W), .DEPTH(DEPTH), .RESET_PC(RESET_PC)
  ) dut (
    .clk(clk), .reset(reset),
    .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
    .iresp_data_ok(iresp_data_ok), .iresp_data(iresp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr),
    .out_ready(out_ready), .out_count(out_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t        q[$];
  logic [63:0] m_fpc;
  logic [63:0] m_pend;
  bit          m_req;
  bit          m_disc;
  bit          en;
  int          n_cmp;
  int          n_bad;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_fpc  = RESET_PC;
    m_pend = '0;
    m_req  = 1'b0;
    m_disc = 1'b0;
  endtask

  // What the outputs must be after this edge, from the queue rules.
  task automatic model_update();
    ent_t e;
    if (redirect_valid) begin
      q.delete();
      if (m_disc) begin
        if (iresp_data_ok) begin
          m_fpc  = redirect_pc;
          m_disc = 1'b0;
        end else begin
          m_pend = redirect_pc;
        end
      end else if (m_req && !iresp_data_ok) begin
        m_disc = 1'b1;
        m_pend = redirect_pc;
      end else begin
        m_fpc = redirect_pc;
      end
      m_req = 1'b1;
    end else begin
      if (q.size() != 0 && out_ready) void'(q.pop_front());
      if (m_disc) begin
        if (iresp_data_ok) begin
          m_disc = 1'b0;
          m_fpc  = m_pend;
        end
        m_req = 1'b1;
      end else if (m_req && iresp_data_ok) begin
        e.pc    = m_fpc;
        e.instr = iresp_data;
        q.push_back(e);
        m_fpc = m_fpc + 64'd4;
        m_req = (q.size() < DEPTH);
      end else if (!m_req) begin
        m_req = (q.size() < DEPTH);
      end
    end
  endtask

  // Per-cycle comparison of every meaningful output against the model.
  always @(negedge clk) begin
    if (en) begin
      check("ireq_valid", 64'(ireq_valid), 64'(m_req));
      if (m_req) check("ireq_addr", ireq_addr, m_fpc);
      check("out_valid", 64'(out_valid), 64'(q.size() != 0));
      check("out_count", 64'(out_count), 64'(q.size()));
      if (q.size() != 0) begin
        check("out_pc", out_pc, q[0].pc);
        check("out_instr", 64'(out_instr), 64'(q[0].instr));
      end
    end
  end

  // Called at a falling edge; returns at the next falling edge.
  task automatic step(input bit dok, input bit rv, input logic [63:0] rpc, input bit rdy);
    iresp_data_ok  = dok && m_req;
    iresp_data     = $urandom;
    redirect_valid = rv;
    redirect_pc    = rpc;
    out_ready      = rdy;
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    en = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check("rst_ireq_valid", 64'(ireq_valid), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_count", 64'(out_count), 64'd0);
    check("rst_out_pc", out_pc, 64'd0);
    check("rst_out_instr", 64'(out_instr), 64'd0);
    model_reset();
    iresp_data_ok  = 1'b0;
    redirect_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    en    = 1'b1;
  endtask

  function automatic logic [63:0] rand_pc();
    logic [63:0] r;
    case ($urandom_range(0, 3))
      0:       r = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 3) * 4);
      1:       r = {$urandom, $urandom};
      default: r = 64'h8000_0000 + 64'($urandom_range(0, 255) * 4);
    endcase
    return r;
  endfunction

  initial begin
    n_cmp = 0;
    n_bad = 0;
    en    = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    apply_reset();

    // Zero-latency bus, decode always ready: two-cycle fill then one per cycle.
    check("t1_idle_req", 64'(ireq_valid), 64'd0);
    step(1, 0, 0, 1);
    check("t1_first_addr", ireq_addr, 64'h8000_0000);
    step(1, 0, 0, 1);
    check("t1_first_pc", out_pc, 64'h8000_0000);
    for (int k = 1; k < 6; k++) begin
      step(1, 0, 0, 1);
      check("t1_seq_pc", out_pc, 64'h8000_0000 + 64'(4 * k));
      check("t1_count_le1", 64'(out_count <= 1), 64'd1);
    end

    // Decode stalled: exactly DEPTH pushes, then fetch resumes after a pop.
    apply_reset();
    step(0, 0, 0, 0);
    for (int k = 0; k < 6; k++) step(1, 0, 0, 0);
    check("t2_count_full", 64'(out_count), 64'd4);
    check("t2_req_off", 64'(ireq_valid), 64'd0);
    check("t2_head_pc", out_pc, 64'h8000_0000);
    step(1, 0, 0, 1);
    check("t2_resume_req", 64'(ireq_valid), 64'd1);
    check("t2_resume_addr", ireq_addr, 64'h8000_0010);
    check("t2_next_head", out_pc, 64'h8000_0004);

    // Redirect during a slow response: old request held, its data dropped.
    apply_reset();
    step(0, 0, 0, 1);
    step(0, 1, 64'h8000_0100, 1);
    check("t3_hold_addr", ireq_addr, 64'h8000_0000);
    check("t3_hold_valid", 64'(ireq_valid), 64'd1);
    step(0, 0, 0, 1);
    check("t3_hold_addr2", ireq_addr, 64'h8000_0000);
    step(1, 0, 0, 1);
    check("t3_dropped", 64'(out_valid), 64'd0);
    check("t3_new_addr", ireq_addr, 64'h8000_0100);
    step(1, 0, 0, 0);
    check("t3_new_pc", out_pc, 64'h8000_0100);

    // Two redirects within one outstanding request: latest wins.
    apply_reset();
    step(0, 0, 0, 1);
    step(0, 1, 64'h8000_0200, 1);
    step(0, 1, 64'h8000_0300, 1);
    step(1, 0, 0, 1);
    check("t4_addr", ireq_addr, 64'h8000_0300);
    check("t4_count", 64'(out_count), 64'd0);

    // Redirect coincident with data_ok and a pop, two entries queued.
    apply_reset();
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    check("t5_count2", 64'(out_count), 64'd2);
    step(1, 1, 64'h8000_0400, 1);
    check("t5_count0", 64'(out_count), 64'd0);
    check("t5_out_valid", 64'(out_valid), 64'd0);
    check("t5_addr", ireq_addr, 64'h8000_0400);

    // Asynchronous reset with a response pending and the queue half full.
    apply_reset();
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    apply_reset();
    step(0, 0, 0, 1);
    check("t6_addr", ireq_addr, 64'h8000_0000);

    // Randomised traffic with varying bus latency, stalls and redirects.
    for (int p = 0; p < 6; p++) begin
      int okp, rdyp, rvp;
      okp  = (p % 3 == 0) ? 100 : ((p % 3 == 1) ? 50 : 20);
      rdyp = (p < 2) ? 90 : ((p < 4) ? 40 : 10);
      rvp  = (p % 2 == 0) ? 4 : 15;
      for (int c = 0; c < 1500; c++) begin
        bit dok, rv, rdy;
        dok = ($urandom_range(0, 99) < okp);
        rv  = ($urandom_range(0, 99) < rvp);
        rdy = ($urandom_range(0, 99) < rdyp);
        if ($urandom_range(0, 999) == 0) apply_reset();
        step(dok, rv, rand_pc(), rdy);
      end
    end

    en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
